// File: rtl/cache_pkg.sv
// Shared cache types: the MESI line-state encoding used by the controller and
// the datapath, plus the controller FSM state encoding.
package cache_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_ALLOCATE  = 3'd3,
    ST_UPGRADE   = 3'd4,
    ST_UPDATE    = 3'd5
  } ctrl_state_t;

  // A line holds usable data in every MESI state except Invalid.
  function automatic logic is_valid(input mesi_t s);
    return s != MESI_I;
  endfunction

endpackage

// File: rtl/cache_controller.sv
// MESI cache controller: sequences lookup, dirty-victim writeback (WriteClean),
// line allocation (ReadShared) and ownership upgrade (MakeUnique) for one
// outstanding CPU request at a time.
module cache_controller
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  output logic       cpu_ready,
  input  logic       cache_hit,
  input  logic [1:0] line_state,
  output logic       lookup_en,
  output logic       data_wr_en,
  output logic       fill_en,
  output logic       state_we,
  output logic [1:0] next_state_o,
  output logic       read_req,
  output logic       write_req,
  output logic       invalid_req,
  input  logic       ace_ready
);

  ctrl_state_t state, state_nxt;
  mesi_t       line_mesi;
  mesi_t       next_mesi;

  assign line_mesi    = mesi_t'(line_state);
  assign next_state_o = next_mesi;

  // State register; synchronous reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore/Mealy outputs; each request stays high until the
  // ace_ready cycle and drops on the following cycle as the state moves on.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt   = state;
    cpu_ready   = 1'b0;
    lookup_en   = 1'b0;
    data_wr_en  = 1'b0;
    fill_en     = 1'b0;
    state_we    = 1'b0;
    next_mesi   = MESI_I;
    read_req    = 1'b0;
    write_req   = 1'b0;
    invalid_req = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          lookup_en = 1'b1;
          state_nxt = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (cache_hit && is_valid(line_mesi)) begin
          if (!cpu_wr) begin
            cpu_ready = 1'b1;
            state_nxt = ST_IDLE;
          end else if (line_mesi == MESI_S) begin
            state_nxt = ST_UPGRADE;
          end else begin
            state_nxt = ST_UPDATE;
          end
        end else if (line_mesi == MESI_M) begin
          state_nxt = ST_WRITEBACK;
        end else begin
          state_nxt = ST_ALLOCATE;
        end
      end

      ST_WRITEBACK: begin
        write_req = 1'b1;
        if (ace_ready) begin
          // WriteClean leaves our copy clean but still unique.
          state_we  = 1'b1;
          next_mesi = MESI_E;
          state_nxt = ST_ALLOCATE;
        end
      end

      ST_ALLOCATE: begin
        read_req = 1'b1;
        if (ace_ready) begin
          fill_en   = 1'b1;
          state_we  = 1'b1;
          next_mesi = MESI_S;
          if (cpu_wr) begin
            state_nxt = ST_UPGRADE;
          end else begin
            cpu_ready = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_UPGRADE: begin
        invalid_req = 1'b1;
        if (ace_ready) state_nxt = ST_UPDATE;
      end

      ST_UPDATE: begin
        data_wr_en = 1'b1;
        state_we   = 1'b1;
        next_mesi  = MESI_M;
        cpu_ready  = 1'b1;
        state_nxt  = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL: cpu_req  input  1  CPU request valid; held until cpu_ready.
REQ-004 SHALL: cpu_wr  input  1  1 = write, 0 = read; stable while cpu_req=1.
REQ-005 SHALL: cpu_ready  output  1  one-cycle completion pulse to CPU.
REQ-006 SHALL: cache_hit  input  1  tag match for the current address, from datapath.
REQ-007 SHALL: line_state  input  2  MESI state of the indexed line: I=00, S=01, E=10, M=11.
REQ-008 SHALL: lookup_en  output  1  datapath latches address and performs tag/state read.
REQ-009 SHALL: data_wr_en  output  1  write CPU data into the indexed line.
REQ-010 SHALL: fill_en  output  1  load line from read response data.
REQ-011 SHALL: state_we  output  1  write next_state_o to line state.
REQ-012 SHALL: next_state_o  output  2  MESI value written when state_we=1.
REQ-013 SHALL: read_req / write_req / invalid_req  output  1 each  ACE transaction requests (ReadShared / WriteClean / MakeUnique).
REQ-014 SHALL: ace_ready  input  1  one-cycle pulse marking completion of the outstanding ACE transaction.

Function
REQ-015 SHALL: FSM states are IDLE, LOOKUP, WRITEBACK, ALLOCATE, UPGRADE and UPDATE.
REQ-016 SHALL: in IDLE with cpu_req=1, assert lookup_en and go to LOOKUP next cycle.
REQ-017 SHALL: in LOOKUP, read hit (cache_hit=1, line_state!=I) asserts cpu_ready and returns to IDLE; total latency 2 cycles.
REQ-018 SHALL: in LOOKUP, write hit in E or M goes to UPDATE.
REQ-019 SHALL: in LOOKUP, write hit in S goes to UPGRADE.
REQ-020 SHALL: in LOOKUP, a miss goes to WRITEBACK if line_state=M (dirty victim), else to ALLOCATE.
REQ-021 SHALL: WRITEBACK holds write_req=1 until ace_ready=1.
  - On ace_ready: state_we=1, next_state_o=E (WriteClean keeps the line clean, unique).
  - Then go to ALLOCATE.
REQ-022 SHALL: ALLOCATE holds read_req=1 until ace_ready=1.
  - On ace_ready: fill_en=1, state_we=1, next_state_o=S.
  - Read: assert cpu_ready and go to IDLE.
  - Write: go to UPGRADE.
REQ-023 SHALL: UPGRADE holds invalid_req=1 until ace_ready=1, then goes to UPDATE.
REQ-024 SHALL: UPDATE asserts data_wr_en, state_we, next_state_o=M and cpu_ready for one cycle, then returns to IDLE.
REQ-025 SHALL: at most one of read_req/write_req/invalid_req is 1 in any cycle.
REQ-026 SHALL: each request deasserts in the cycle after ace_ready is sampled, so no duplicate transaction is issued.
REQ-027 SHALL: ace_ready outside WRITEBACK/ALLOCATE/UPGRADE is ignored.
REQ-028 SHALL: cpu_req is ignored outside IDLE; no new request is accepted until cpu_ready has pulsed.
REQ-029 SHALL: cpu_ready is asserted exactly once per accepted request.
REQ-030 SHALL: every output not named active in the current state/condition is 0.

Reset
REQ-031 SHALL: rst=1 at a clock edge forces IDLE.
  - All outputs 0 in the following cycle, including mid-transaction; any outstanding ACE request is abandoned.
REQ-032 SHALL: the first cpu_req is accepted in the first cycle with rst=0.

Structure
REQ-033 SHALL: the MESI encoding enum and FSM state enum live in shared package cache_pkg, also used by the datapath.
REQ-034 SHALL: implementation is a single module, with one sequential state register and one combinational next-state/output block; no sub-modules.

Verification
REQ-035 SHALL: read hit, line_state=E -> cpu_ready exactly 2 cycles after cpu_req; no ACE request.
REQ-036 SHALL: write hit in S -> invalid_req until ace_ready; then UPDATE with data_wr_en=1, next_state_o=11, cpu_ready=1.
REQ-037 SHALL: read miss, victim M -> write_req, then (after ace_ready) read_req.
  - Final fill_en=1, next_state_o=01, cpu_ready=1.
  - write_req and read_req never overlap.
REQ-038 SHALL: write miss, victim I -> read_req, then invalid_req, then UPDATE to M; cpu_ready pulses exactly once.
REQ-039 SHALL: rst=1 while in UPGRADE with ace_ready pending -> next cycle IDLE, invalid_req=0, cpu_ready=0.
REQ-040 SHALL: ace_ready delayed 20 cycles -> request held steadily high for all 20 cycles, deasserted the cycle after ace_ready.
